// File: rtl/serdes_pkg.sv
// Shared definitions for the LSB-first serial link: FSM encoding, width helper
// and the default framing pattern used by both ends of the link.
package serdes_pkg;

  typedef enum logic {
    ST_HUNT   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  localparam int unsigned DEFAULT_SYNC_W = 8;
  localparam logic [DEFAULT_SYNC_W-1:0] DEFAULT_SYNC_WORD = 8'hA5;

  // Ceiling log2, with a floor of 1 bit so single-value counters still have a width.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    while ((32'd1 << result) < value) result++;
    if (result == 0) result = 1;
    return result;
  endfunction

endpackage

// File: rtl/deserializer_sync.sv
// Serial-to-parallel receiver: hunts for the sync word bit-by-bit, then
// assembles each following DATA_WIDTH bits (LSB first) into a parallel word.
module deserializer_sync
  import serdes_pkg::*;
#(
  parameter int unsigned               DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0]     SYNC_WORD  = DATA_WIDTH'(DEFAULT_SYNC_WORD)
) (
  input  logic                  clock_in,
  input  logic                  reset_n,
  input  logic                  serial_in,
  input  logic                  bit_en,
  input  logic                  resync,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  locked
);

  localparam int unsigned CNT_W  = clog2(DATA_WIDTH);
  localparam int unsigned FILL_W = clog2(DATA_WIDTH + 1);

  state_t                  state_q, state_d;
  // Only the upper DATA_WIDTH-1 bits of the window survive to the next shift.
  logic [DATA_WIDTH-2:0]   hist_q, hist_d;
  logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic [FILL_W-1:0]       fill_q, fill_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    valid_q, valid_d;
  logic [DATA_WIDTH-1:0]   shift_next_c;
  logic [FILL_W-1:0]       fill_inc_c;

  assign shift_next_c = {serial_in, hist_q};

  // State and datapath registers.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_HUNT;
      hist_q    <= '0;
      bit_cnt_q <= '0;
      fill_q    <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      hist_q    <= hist_d;
      bit_cnt_q <= bit_cnt_d;
      fill_q    <= fill_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
    end
  end

  // Next-state and datapath logic; resync wins over a coincident bit.
  always_comb begin
    state_d    = state_q;
    hist_d     = hist_q;
    bit_cnt_d  = bit_cnt_q;
    fill_d     = fill_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    fill_inc_c = (fill_q == FILL_W'(DATA_WIDTH)) ? fill_q : fill_q + FILL_W'(1);

    if (resync) begin
      state_d   = ST_HUNT;
      hist_d    = '0;
      bit_cnt_d = '0;
      fill_d    = '0;
    end else if (bit_en) begin
      hist_d = shift_next_c[DATA_WIDTH-1:1];
      unique case (state_q)
        ST_HUNT: begin
          fill_d = fill_inc_c;
          // Full window required so reset contents never match.
          if ((fill_inc_c == FILL_W'(DATA_WIDTH)) && (shift_next_c == SYNC_WORD)) begin
            state_d   = ST_LOCKED;
            bit_cnt_d = '0;
          end
        end
        ST_LOCKED: begin
          if (bit_cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
            data_d    = shift_next_c;
            valid_d   = 1'b1;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
        default: state_d = ST_HUNT;
      endcase
    end
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign locked     = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_deserializer_sync.sv
// Directed bench for deserializer_sync: default 0xA5 sync instance plus a
// zero-sync-word instance sharing the serial stimulus.
module tb_deserializer_sync;

  logic       clock_in = 1'b0;
  logic       reset_n;
  logic       reset_n_z;
  logic       serial_in;
  logic       bit_en;
  logic       resync;
  logic [7:0] data_out;
  logic       data_valid;
  logic       locked;
  logic [7:0] data_out_z;
  logic       data_valid_z;
  logic       locked_z;

  int errors = 0;
  int checks = 0;

  always #5 clock_in = ~clock_in;

  deserializer_sync #(.DATA_WIDTH(8), .SYNC_WORD(8'hA5)) dut (
    .clock_in  (clock_in),
    .reset_n   (reset_n),
    .serial_in (serial_in),
    .bit_en    (bit_en),
    .resync    (resync),
    .data_out  (data_out),
    .data_valid(data_valid),
    .locked    (locked)
  );

  deserializer_sync #(.DATA_WIDTH(8), .SYNC_WORD(8'h00)) dut_z (
    .clock_in  (clock_in),
    .reset_n   (reset_n_z),
    .serial_in (serial_in),
    .bit_en    (bit_en),
    .resync    (resync),
    .data_out  (data_out_z),
    .data_valid(data_valid_z),
    .locked    (locked_z)
  );

  // Apply inputs, advance one rising edge, return 1 time unit after it.
  task automatic step(input logic s, input logic e, input logic r);
    serial_in = s;
    bit_en    = e;
    resync    = r;
    @(posedge clock_in);
    #1;
  endtask

  // Sends one word LSB first; checks valid only on the final bit.
  task automatic send_word(input logic [7:0] w, input bit gap, input string tag);
    for (int i = 0; i < 8; i++) begin
      step(w[i], 1'b1, 1'b0);
      checks++;
      if (i < 7) begin
        if (data_valid !== 1'b0) begin
          errors++;
          $display("FAIL %s early_valid bit=%0d got=%b exp=0", tag, i, data_valid);
        end
      end else begin
        if (data_valid !== 1'b1 || data_out !== w || locked !== 1'b1) begin
          errors++;
          $display("FAIL %s word valid=%b data=%h locked=%b exp valid=1 data=%h locked=1",
                   tag, data_valid, data_out, locked, w);
        end
      end
      if (gap && i < 7) begin
        step(1'b0, 1'b0, 1'b0);
        checks++;
        if (data_valid !== 1'b0) begin
          errors++;
          $display("FAIL %s gap_valid bit=%0d got=%b exp=0", tag, i, data_valid);
        end
      end
    end
  endtask

  task automatic test_reset;
    for (int i = 0; i < 6; i++) begin
      step(1'($urandom_range(1)), 1'($urandom_range(1)), 1'b0);
      checks++;
      if (data_out !== 8'h00 || data_valid !== 1'b0 || locked !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold cyc=%0d data=%h valid=%b locked=%b exp 00/0/0",
                 i, data_out, data_valid, locked);
      end
    end
    reset_n = 1'b1;
  endtask

  task automatic test_lock;
    logic [10:0] bits;
    bits = 11'b10100101_011;  // junk 1,1,0 then 0xA5 LSB first, bit 0 sent first
    for (int i = 0; i < 11; i++) begin
      step(bits[i], 1'b1, 1'b0);
      checks++;
      if (data_valid !== 1'b0 || locked !== (i == 10)) begin
        errors++;
        $display("FAIL lock bit=%0d locked=%b valid=%b exp locked=%b valid=0",
                 i, locked, data_valid, (i == 10));
      end
    end
  endtask

  task automatic test_data;
    send_word(8'h3C, 1'b0, "data_3c");
    send_word(8'hA5, 1'b0, "data_a5");
    step(1'b0, 1'b0, 1'b0);
    checks++;
    if (data_valid !== 1'b0 || data_out !== 8'hA5 || locked !== 1'b1) begin
      errors++;
      $display("FAIL data_hold valid=%b data=%h locked=%b exp 0/a5/1",
               data_valid, data_out, locked);
    end
  endtask

  task automatic test_gapped;
    send_word(8'h81, 1'b1, "gapped_81");
    step(1'b0, 1'b0, 1'b0);
    checks++;
    if (data_valid !== 1'b0 || data_out !== 8'h81) begin
      errors++;
      $display("FAIL gapped_single valid=%b data=%h exp 0/81", data_valid, data_out);
    end
  endtask

  task automatic test_resync;
    logic [7:0] sync;
    sync = 8'hA5;
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    checks++;
    if (locked !== 1'b0 || data_valid !== 1'b0 || data_out !== 8'h81) begin
      errors++;
      $display("FAIL resync_drop locked=%b valid=%b data=%h exp 0/0/81",
               locked, data_valid, data_out);
    end
    for (int i = 0; i < 8; i++) begin
      step(sync[i], 1'b1, 1'b0);
      checks++;
      if (data_valid !== 1'b0 || locked !== (i == 7)) begin
        errors++;
        $display("FAIL resync_relock bit=%0d locked=%b valid=%b exp locked=%b valid=0",
                 i, locked, data_valid, (i == 7));
      end
    end
    send_word(8'h77, 1'b0, "resync_77");
  endtask

  task automatic test_async_reset_mid_word;
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (data_out !== 8'h00 || data_valid !== 1'b0 || locked !== 1'b0) begin
      errors++;
      $display("FAIL async_reset data=%h valid=%b locked=%b exp 00/0/0",
               data_out, data_valid, locked);
    end
    step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_zero_sync;
    reset_n_z = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step((i == 7), 1'b1, 1'b0);
      checks++;
      if (locked_z !== 1'b0 || data_valid_z !== 1'b0) begin
        errors++;
        $display("FAIL zero_nolock bit=%0d locked=%b valid=%b exp 0/0",
                 i, locked_z, data_valid_z);
      end
    end
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 1'b0);
      checks++;
      if (locked_z !== (i == 7) || data_valid_z !== 1'b0) begin
        errors++;
        $display("FAIL zero_lock bit=%0d locked=%b valid=%b exp locked=%b valid=0",
                 i, locked_z, data_valid_z, (i == 7));
      end
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    reset_n_z = 1'b0;
    serial_in = 1'b0;
    bit_en    = 1'b0;
    resync    = 1'b0;
    test_reset;
    test_lock;
    test_data;
    test_gapped;
    test_resync;
    test_async_reset_mid_word;
    test_zero_sync;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
